ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16: RAM address width.
REQ-002 SHALL have parameter RAM_WIDTH, default 16: RAM data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, range 1..255: maximum consecutive loader accesses per grant.
REQ-004 SHALL have parameter STALL_CNT_WIDTH, default 16: width of the swallowed-step counter.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk input 1 (system clock, rising edge); rst_n input 1 (asynchronous active-low reset).
REQ-006 SHALL have these ports:
- i_clk_en input 1: CPU step strobe.
- o_clk_en output 1: gated step strobe to the datapath.
- i_halt input 1: CPU halted.
- i_cpu_addr input ADDRESS_WIDTH, i_cpu_we input 1, i_cpu_wdata input RAM_WIDTH: CPU RAM port.
- i_ld_req input 1, i_ld_we input 1, i_ld_addr input ADDRESS_WIDTH, i_ld_wdata input RAM_WIDTH: loader request.
- o_ld_gnt output 1: loader access accepted.
- o_ld_rvalid output 1, o_ld_rdata output RAM_WIDTH: loader response.
- o_ram_addr output ADDRESS_WIDTH, o_ram_we output 1, o_ram_wdata output RAM_WIDTH, i_ram_rdata input RAM_WIDTH: RAM port. The RAM writes on the clk edge when o_ram_we=1 and returns read data one cycle after the address is presented.
- i_stall_clr input 1: synchronous clear of o_stall_cnt.
- o_stall_cnt output STALL_CNT_WIDTH: swallowed CPU steps.
- o_busy output 1: loader owns the RAM.

Function
REQ-007 SHALL implement three states: CPU_OWN, LD_OWN, LD_RESP.
REQ-008 In CPU_OWN, the RAM port SHALL carry the CPU signals, with o_ram_we = i_cpu_we & o_clk_en and o_clk_en = i_clk_en | pend. Outputs o_ld_gnt, o_ld_rvalid and o_busy SHALL be 0.
REQ-009 In CPU_OWN, state SHALL move to LD_OWN next cycle when i_ld_req=1 and lockout=0. If i_clk_en=1 in that same cycle, that CPU step SHALL complete first.
REQ-010 In LD_OWN, the RAM port SHALL carry the loader signals.
- o_ld_gnt = i_ld_req; o_ram_we = i_ld_we & i_ld_req; o_busy=1.
- When i_ld_req=1: access accepted, burst count incremented, next state LD_RESP.
- When i_ld_req=0: next state CPU_OWN, no RAM access.
REQ-011 In LD_RESP, o_ld_rvalid SHALL be 1 and o_ld_rdata SHALL equal i_ram_rdata. rvalid SHALL also pulse for writes, as an acknowledge.
REQ-012 From LD_RESP, state SHALL move to LD_OWN when i_ld_req=1 and (burst count < MAX_BURST or i_halt=1). Otherwise it SHALL move to CPU_OWN and clear the burst count.
REQ-013 On leaving LD_RESP because burst count = MAX_BURST and i_halt=0, lockout SHALL be set. Lockout SHALL clear on the first cycle in which o_clk_en=1.
REQ-014 In LD_OWN and LD_RESP, o_clk_en SHALL be 0.
- Each i_clk_en=1 cycle is swallowed.
- First swallowed pulse: pend is set.
- Later swallowed pulses while pend=1: dropped, o_stall_cnt incremented.
REQ-015 pend SHALL clear on the cycle o_clk_en=1. A pending pulse coinciding with i_clk_en=1 SHALL yield one o_clk_en pulse, with pend cleared and no count.
REQ-016 o_stall_cnt SHALL saturate at all-ones. i_stall_clr SHALL take priority over increment.
REQ-017 Loader address and data SHALL be ignored outside LD_OWN. CPU writes during LD_OWN/LD_RESP SHALL never reach the RAM.

Reset
REQ-018 rst_n=0 SHALL immediately force:
- state CPU_OWN; pend, lockout and burst count to 0; o_stall_cnt to 0.
- o_ld_gnt, o_ld_rvalid, o_busy, o_ram_we to 0. o_clk_en = i_clk_en.
REQ-019 Reset during LD_OWN/LD_RESP SHALL abort the access without a response. A write accepted before reset has already completed.

Structure
REQ-020 State encodings (CPU_OWN=2'd0, LD_OWN=2'd1, LD_RESP=2'd2) SHALL live in the shared package sap2_pkg.
REQ-021 The saturating counter SHALL be sub-module sat_counter (parameters WIDTH; inputs inc, clr).

Verification
REQ-022 Loader write addr 0x0010 data 0xBEEF with CPU idle -> gnt at cycle 2, rvalid cycle 3; a following read of 0x0010 returns 0xBEEF.
REQ-023 i_ld_req rises in the same cycle as i_clk_en=1 with i_cpu_we=1 at addr 0x0005 data 0x1234 -> CPU write lands, o_clk_en=1 that cycle, LD_OWN next cycle.
REQ-024 Continuous i_ld_req, i_halt=0, MAX_BURST=4 -> exactly 4 grants, then CPU_OWN until one o_clk_en pulse, then the loader is regranted.
REQ-025 Same as REQ-024 with i_halt=1 -> grants continue unbroken for 20 accesses.
REQ-026 Three i_clk_en pulses during a loader burst -> one deferred o_clk_en after return; o_stall_cnt=2; i_stall_clr -> 0; saturation checked with STALL_CNT_WIDTH=2.
REQ-027 rst_n asserted in LD_RESP -> o_ld_rvalid and o_busy drop the same cycle; CPU_OWN after release.

Source files
------------

// File: rtl/sap2_pkg.sv
// Shared definitions for the RAM port arbiter: ownership state encodings
// and the width of the loader burst counter.
package sap2_pkg;

   localparam logic [1:0] CPU_OWN = 2'd0;
   localparam logic [1:0] LD_OWN  = 2'd1;
   localparam logic [1:0] LD_RESP = 2'd2;

   localparam int unsigned BURST_CNT_WIDTH = 8;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Loader request/response handshake into the RAM port arbiter.
interface ram_port_arbiter_if #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned RAM_WIDTH     = 16
);

   logic                     i_ld_req;
   logic                     i_ld_we;
   logic [ADDRESS_WIDTH-1:0] i_ld_addr;
   logic [RAM_WIDTH-1:0]     i_ld_wdata;
   logic                     o_ld_gnt;
   logic                     o_ld_rvalid;
   logic [RAM_WIDTH-1:0]     o_ld_rdata;

   modport slave (
      input  i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata,
      output o_ld_gnt, o_ld_rvalid, o_ld_rdata
   );

   modport master (
      output i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata,
      input  o_ld_gnt, o_ld_rvalid, o_ld_rdata
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between a stepping CPU and a bulk loader; CPU steps
// swallowed while the loader owns the RAM are deferred (one) or counted.
module ram_port_arbiter
   import sap2_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH   = 16,
   parameter int unsigned RAM_WIDTH       = 16,
   parameter int unsigned MAX_BURST       = 4,
   parameter int unsigned STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_clk_en,
   output logic                       o_clk_en,
   input  logic                       i_halt,
   input  logic [ADDRESS_WIDTH-1:0]   i_cpu_addr,
   input  logic                       i_cpu_we,
   input  logic [RAM_WIDTH-1:0]       i_cpu_wdata,
   ram_port_arbiter_if.slave          ld,
   output logic [ADDRESS_WIDTH-1:0]   o_ram_addr,
   output logic                       o_ram_we,
   output logic [RAM_WIDTH-1:0]       o_ram_wdata,
   input  logic [RAM_WIDTH-1:0]       i_ram_rdata,
   input  logic                       i_stall_clr,
   output logic [STALL_CNT_WIDTH-1:0] o_stall_cnt,
   output logic                       o_busy
);

   localparam logic [BURST_CNT_WIDTH-1:0] MAX_B = MAX_BURST[BURST_CNT_WIDTH-1:0];

   logic [1:0]                 state;
   logic [1:0]                 state_nxt;
   logic                       pend;
   logic                       lockout;
   logic [BURST_CNT_WIDTH-1:0] burst_cnt;
   logic                       cpu_own;
   logic                       ld_own;
   logic                       ld_resp;
   logic                       swallow;
   logic                       accept;
   logic                       burst_left;
   logic                       lock_set;

   assign cpu_own    = (state == CPU_OWN);
   assign ld_own     = (state == LD_OWN);
   assign ld_resp    = (state == LD_RESP);
   assign o_clk_en   = cpu_own & (i_clk_en | pend);
   assign swallow    = ~cpu_own & i_clk_en;
   assign accept     = ld_own & ld.i_ld_req;
   assign burst_left = (burst_cnt < MAX_B) | i_halt;
   // Lockout only when the loader wanted more but the burst ran out.
   assign lock_set   = ld_resp & ld.i_ld_req & ~burst_left;

   always_comb begin
      state_nxt = state;
      case (state)
         CPU_OWN: if (ld.i_ld_req && !lockout) state_nxt = LD_OWN;
         LD_OWN:  state_nxt = ld.i_ld_req ? LD_RESP : CPU_OWN;
         LD_RESP: state_nxt = (ld.i_ld_req && burst_left) ? LD_OWN : CPU_OWN;
         default: state_nxt = CPU_OWN;
      endcase
   end

   always_comb begin
      o_ram_addr  = i_cpu_addr;
      o_ram_wdata = i_cpu_wdata;
      o_ram_we    = 1'b0;
      if (cpu_own) begin
         o_ram_we = i_cpu_we & o_clk_en & rst_n;
      end else if (ld_own) begin
         o_ram_addr  = ld.i_ld_addr;
         o_ram_wdata = ld.i_ld_wdata;
         o_ram_we    = ld.i_ld_we & ld.i_ld_req;
      end
   end

   assign ld.o_ld_gnt    = accept;
   assign ld.o_ld_rvalid = ld_resp;
   assign ld.o_ld_rdata  = i_ram_rdata;
   assign o_busy         = ~cpu_own;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CPU_OWN;
         pend      <= 1'b0;
         lockout   <= 1'b0;
         burst_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (o_clk_en)     pend <= 1'b0;
         else if (swallow) pend <= 1'b1;
         if (o_clk_en)      lockout <= 1'b0;
         else if (lock_set) lockout <= 1'b1;
         if (state_nxt == CPU_OWN)              burst_cnt <= '0;
         else if (accept && (burst_cnt != '1))  burst_cnt <= burst_cnt + 1'b1;
      end
   end

   sat_counter #(
      .WIDTH(STALL_CNT_WIDTH)
   ) u_stall_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (swallow & pend),
      .clr  (i_stall_clr),
      .count(o_stall_cnt)
   );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small RAM model and a
// scoreboard of expected loader responses.
module tb_ram_port_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned RW = 16;
   localparam int unsigned SW = 2;

   typedef struct {
      logic          chk;
      logic [RW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          clk_en;
   logic          clk_en_out;
   logic          halt;
   logic [AW-1:0] cpu_addr;
   logic          cpu_we;
   logic [RW-1:0] cpu_wdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [RW-1:0] ram_wdata;
   logic [RW-1:0] ram_rdata;
   logic          stall_clr;
   logic [SW-1:0] stall_cnt;
   logic          busy;
   logic [RW-1:0] mem [0:255];

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   ram_port_arbiter_if #(.ADDRESS_WIDTH(AW), .RAM_WIDTH(RW)) ld_if ();

   ram_port_arbiter #(
      .ADDRESS_WIDTH  (AW),
      .RAM_WIDTH      (RW),
      .MAX_BURST      (4),
      .STALL_CNT_WIDTH(SW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clk_en   (clk_en),
      .o_clk_en   (clk_en_out),
      .i_halt     (halt),
      .i_cpu_addr (cpu_addr),
      .i_cpu_we   (cpu_we),
      .i_cpu_wdata(cpu_wdata),
      .ld         (ld_if),
      .o_ram_addr (ram_addr),
      .o_ram_we   (ram_we),
      .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata),
      .i_stall_clr(stall_clr),
      .o_stall_cnt(stall_cnt),
      .o_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: synchronous write, one-cycle read latency
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[7:0]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic push(input logic chk, input logic [RW-1:0] data);
      exp_t e;
      e.chk  = chk;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic ld_drive(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [RW-1:0] wdata);
      ld_if.i_ld_req   = req;
      ld_if.i_ld_we    = we;
      ld_if.i_ld_addr  = addr;
      ld_if.i_ld_wdata = wdata;
   endtask

   // Monitor: every loader response pops one scoreboard entry
   always @(negedge clk) begin
      if (ld_if.o_ld_rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected: got rvalid=1 expected no response");
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk) check("ld_rdata", {16'h0, ld_if.o_ld_rdata}, {16'h0, mon_e.data});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int g;
      int gap;
      logic found;

      rst_n = 1'b0; clk_en = 1'b1; halt = 1'b0; stall_clr = 1'b0;
      cpu_addr = 16'h0003; cpu_we = 1'b1; cpu_wdata = 16'hAAAA;
      ld_drive(1'b1, 1'b1, 16'h0003, 16'h5A5A);

      // Reset state
      sample();
      check("rst_clk_en", clk_en_out, 1);
      check("rst_ram_we", ram_we, 0);
      check("rst_gnt", ld_if.o_ld_gnt, 0);
      check("rst_rvalid", ld_if.o_ld_rvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_stall", stall_cnt, 0);
      clk_en = 1'b0; cpu_we = 1'b0;
      ld_drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Loader write then read-back with CPU idle
      ld_drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
      sample();
      check("wr_gnt_c1", ld_if.o_ld_gnt, 0);
      tick();
      sample();
      check("wr_gnt_c2", ld_if.o_ld_gnt, 1);
      check("wr_busy_c2", busy, 1);
      check("wr_ram_we_c2", ram_we, 1);
      check("wr_ram_addr_c2", ram_addr, 16'h0010);
      push(1'b0, '0);
      tick();
      ld_drive(1'b1, 1'b0, 16'h0010, 16'h0);
      sample();
      check("resp_gnt_c3", ld_if.o_ld_gnt, 0);
      tick();
      sample();
      check("rd_gnt_c4", ld_if.o_ld_gnt, 1);
      check("rd_ram_we_c4", ram_we, 0);
      push(1'b1, 16'hBEEF);
      tick();
      ld_drive(1'b0, 1'b0, 16'h0, 16'h0);
      sample();
      tick();
      sample();
      check("idle_busy", busy, 0);
      tick();

      // CPU step coinciding with loader request completes first
      clk_en = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'h1234;
      ld_drive(1'b1, 1'b0, 16'h0005, 16'h0);
      sample();
      check("cpu_step_clk_en", clk_en_out, 1);
      check("cpu_step_ram_we", ram_we, 1);
      check("cpu_step_addr", ram_addr, 16'h0005);
      check("cpu_step_wdata", ram_wdata, 16'h1234);
      check("cpu_step_gnt", ld_if.o_ld_gnt, 0);
      tick();
      clk_en = 1'b0; cpu_we = 1'b0;
      sample();
      check("ld_after_cpu_gnt", ld_if.o_ld_gnt, 1);
      check("ld_after_cpu_clk_en", clk_en_out, 0);
      push(1'b1, 16'h1234);
      tick();
      ld_drive(1'b0, 1'b0, 16'h0, 16'h0);
      clk_en = 1'b1; cpu_we = 1'b1; cpu_wdata = 16'hDEAD;
      sample();
      check("blocked_clk_en", clk_en_out, 0);
      check("blocked_ram_we", ram_we, 0);
      tick();
      clk_en = 1'b0; cpu_we = 1'b0;
      sample();
      check("deferred_step", clk_en_out, 1);
      tick();
      sample();
      check("deferred_once", clk_en_out, 0);
      tick();

      // Continuous requests, no halt: burst of 4 then lockout
      ld_drive(1'b1, 1'b0, 16'h0010, 16'h0);
      g = 0;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (ld_if.o_ld_gnt === 1'b1) begin
            g++;
            push(1'b1, 16'hBEEF);
         end
         tick();
      end
      check("burst_grants", g, 4);
      check("lockout_busy", busy, 0);
      clk_en = 1'b1;
      sample();
      check("lockout_step", clk_en_out, 1);
      check("lockout_step_gnt", ld_if.o_ld_gnt, 0);
      tick();
      clk_en = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sample();
         if (ld_if.o_ld_gnt === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("regrant", found, 1);
      if (found) push(1'b1, 16'hBEEF);
      tick();
      ld_drive(1'b0, 1'b0, 16'h0, 16'h0);
      sample();
      tick();

      // Continuous requests with halt: no break over 20 accesses
      halt = 1'b1;
      ld_drive(1'b1, 1'b0, 16'h0010, 16'h0);
      g = 0; gap = 0;
      for (int i = 0; i < 60; i++) begin
         sample();
         if (ld_if.o_ld_gnt === 1'b1) begin
            g++;
            push(1'b1, 16'hBEEF);
         end else if (g > 0 && busy !== 1'b1) begin
            gap++;
         end
         if (g >= 20) break;
         tick();
      end
      check("halt_grants", g, 20);
      check("halt_gaps", gap, 0);
      tick();
      ld_drive(1'b0, 1'b0, 16'h0, 16'h0);
      sample();
      tick();
      halt = 1'b0;
      sample();
      check("halt_release_busy", busy, 0);
      tick();

      // Three swallowed steps during a burst
      ld_drive(1'b1, 1'b0, 16'h0005, 16'h0);
      sample();
      tick();
      g = 0;
      for (int i = 1; i <= 8; i++) begin
         ld_if.i_ld_req = (i <= 7);
         clk_en = (i == 2) || (i == 4) || (i == 5);
         cpu_we = clk_en; cpu_addr = 16'h0005; cpu_wdata = 16'hDEAD;
         sample();
         check("swallow_clk_en", clk_en_out, 0);
         check("swallow_ram_we", ram_we, 0);
         if (ld_if.o_ld_gnt === 1'b1) begin
            g++;
            push(1'b1, 16'h1234);
         end
         tick();
      end
      check("swallow_grants", g, 4);
      clk_en = 1'b0; cpu_we = 1'b0;
      ld_drive(1'b0, 1'b0, 16'h0, 16'h0);
      sample();
      check("swallow_deferred", clk_en_out, 1);
      check("stall_cnt_2", stall_cnt, 2);
      tick();
      sample();
      check("swallow_single", clk_en_out, 0);
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      sample();
      check("stall_clr", stall_cnt, 0);
      tick();

      // Saturation, clear priority, pending pulse merging with a live step
      ld_drive(1'b1, 1'b0, 16'h0010, 16'h0);
      sample();
      tick();
      for (int i = 1; i <= 6; i++) begin
         ld_if.i_ld_req = (i <= 5);
         clk_en = 1'b1;
         stall_clr = (i == 6);
         sample();
         if (ld_if.o_ld_gnt === 1'b1) push(1'b1, 16'hBEEF);
         if (i == 6) check("stall_sat", stall_cnt, 3);
         tick();
      end
      stall_clr = 1'b0;
      sample();
      check("merge_clk_en", clk_en_out, 1);
      check("clr_priority", stall_cnt, 0);
      tick();
      clk_en = 1'b0;
      sample();
      check("merge_single", clk_en_out, 0);
      check("merge_no_count", stall_cnt, 0);
      tick();

      // Reset during LD_RESP aborts the response; the write stays done
      ld_drive(1'b1, 1'b1, 16'h0020, 16'h5555);
      sample();
      tick();
      sample();
      check("abort_gnt", ld_if.o_ld_gnt, 1);
      tick();
      ld_drive(1'b0, 1'b0, 16'h0, 16'h0);
      check("abort_pre_rvalid", ld_if.o_ld_rvalid, 1);
      check("abort_pre_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_rvalid", ld_if.o_ld_rvalid, 0);
      check("abort_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      sample();
      check("abort_after_busy", busy, 0);
      check("abort_after_gnt", ld_if.o_ld_gnt, 0);
      tick();
      ld_drive(1'b1, 1'b0, 16'h0020, 16'h0);
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sample();
         if (ld_if.o_ld_gnt === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("abort_readback_gnt", found, 1);
      if (found) push(1'b1, 16'h5555);
      tick();
      ld_drive(1'b0, 1'b0, 16'h0, 16'h0);
      sample();
      tick();
      tick();

      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
